// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core (FIPS-197), encrypt only, one round per clock.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - synchronous active-high reset (aborts any operation in flight)
//   start    - one-cycle request, accepted only while ready=1
//   keyIn    - 128-bit cipher key, bits [127:120] are key byte 0
//   data_in  - 128-bit plaintext, bits [127:120] are state byte 0 (column-major)
//   ready    - 1 = idle / data_out valid, 0 = encryption in progress
//   data_out - 128-bit ciphertext, held stable until the next final round or reset
module aes128_encrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] keyIn,
  input  logic [127:0] data_in,
  output logic         ready,
  output logic [127:0] data_out
);

  // Index 0 of a blk_t is the most significant byte, matching FIPS-197 byte order.
  typedef logic [0:15][7:0] blk_t;
  typedef logic [0:3][31:0] words_t;

  typedef enum logic {ST_IDLE, ST_BUSY} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  blk_t         state_q, state_d;
  words_t       key_q, key_d;
  logic [127:0] dout_q, dout_d;

  // Round datapath
  blk_t        sb, sr, mc;
  words_t      nk;
  logic [31:0] ktmp;
  logic [7:0]  a0, a1, a2, a3;

  always_comb begin
    sb   = '0;
    sr   = '0;
    mc   = '0;
    nk   = '0;
    ktmp = '0;
    a0   = '0;
    a1   = '0;
    a2   = '0;
    a3   = '0;

    for (int unsigned i = 0; i < 16; i++) begin
      sb[4'(i)] = sbox(state_q[4'(i)]);
    end

    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sr[4'(r + 4 * c)] = sb[4'(r + 4 * ((c + r) % 4))];
      end
    end

    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[4'(4 * c)];
      a1 = sr[4'(4 * c + 1)];
      a2 = sr[4'(4 * c + 2)];
      a3 = sr[4'(4 * c + 3)];
      mc[4'(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4'(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4'(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4'(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    // SubWord(RotWord(w3)) XOR Rcon, then chained across the four words.
    ktmp = {sbox(key_q[3][23:16]), sbox(key_q[3][15:8]),
            sbox(key_q[3][7:0]),   sbox(key_q[3][31:24])}
           ^ {rcon(round_q), 24'h000000};
    nk[0] = key_q[0] ^ ktmp;
    nk[1] = key_q[1] ^ nk[0];
    nk[2] = key_q[2] ^ nk[1];
    nk[3] = key_q[3] ^ nk[2];
  end

  // Control / next-state
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    key_d   = key_q;
    dout_d  = dout_q;

    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = data_in ^ keyIn;
          key_d   = keyIn;
          round_d = 4'd1;
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        key_d = nk;
        if (round_q == 4'd10) begin
          dout_d  = sr ^ nk;
          round_d = 4'd0;
          fsm_d   = ST_IDLE;
        end else begin
          state_d = mc ^ nk;
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      round_q <= '0;
      state_q <= '0;
      key_q   <= '0;
      dout_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      key_q   <= key_d;
      dout_q  <= dout_d;
    end
  end

  assign ready    = (fsm_q == ST_IDLE);
  assign data_out = dout_q;

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core: byte-level AES reference model
// (S-box derived from GF(2^8) inversion + affine map), a cycle-level latency
// model, directed FIPS-197 vectors and randomized stimulus.
module tb_aes128_encrypt_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] keyIn;
  logic [127:0] data_in;
  logic         ready;
  logic [127:0] data_out;

  aes128_encrypt_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .keyIn    (keyIn),
    .data_in  (data_in),
    .ready    (ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference AES ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] tw [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127 - 8 * i -: 8];
      k[i] = key[127 - 8 * i -: 8];
      s[i] ^= k[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[r + 4 * c] = gmul(t[4 * c + r], 8'h02) ^ gmul(t[4 * c + (r + 1) % 4], 8'h03)
                         ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
          else
            s[r + 4 * c] = t[r + 4 * c];
        end
      end
      tw[0] = sbox_t[k[13]] ^ rc;
      tw[1] = sbox_t[k[14]];
      tw[2] = sbox_t[k[15]];
      tw[3] = sbox_t[k[12]];
      for (int j = 0; j < 16; j++)
        k[j] ^= (j < 4) ? tw[j] : k[j - 4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- cycle model + compare ----------------
  int           m_cnt = 0;
  logic [127:0] m_pend;
  logic [127:0] exp_dout = '0;
  logic         exp_ready = 1'b1;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt    = 0;
      exp_dout = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend = aes_model(keyIn, data_in);
        m_cnt  = 10;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) exp_dout = m_pend;
    end
    exp_ready = (m_cnt == 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", {127'h0, ready}, {127'h0, exp_ready});
      chk("cyc_data_out", data_out, exp_dout);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called on a negedge; returns on the negedge where ready is seen high again.
  task automatic run_op(input logic [127:0] k, input logic [127:0] p, output int lowcyc);
    start   = 1'b1;
    keyIn   = k;
    data_in = p;
    @(negedge clk);
    start   = 1'b0;
    keyIn   = rnd128();
    data_in = rnd128();
    lowcyc  = 0;
    while (!ready && lowcyc < 30) begin
      lowcyc++;
      @(negedge clk);
    end
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int lowcyc;
    int rises;
    logic prev;

    rst     = 1'b1;
    start   = 1'b0;
    keyIn   = '0;
    data_in = '0;
    build_sbox();

    chk("model_sbox00", {120'h0, sbox_t[0]}, 128'h63);
    chk("model_sbox53", {120'h0, sbox_t[8'h53]}, 128'hed);
    chk("model_appB", aes_model(KEY_B, PT_B), CT_B);
    chk("model_zero", aes_model('0, 128'h1), CT_Z);
    chk("model_appC", aes_model(KEY_C, PT_C), CT_C);

    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_ready", {127'h0, ready}, 128'h1);
    chk("rst_data_out", data_out, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready", {127'h0, ready}, 128'h1);
    chk("idle_data_out", data_out, '0);

    run_op(KEY_B, PT_B, lowcyc);
    chk("appB_latency", 128'(lowcyc), 128'd10);
    chk("appB_ct", data_out, CT_B);

    run_op('0, 128'h1, lowcyc);
    chk("b2b_latency", 128'(lowcyc), 128'd10);
    chk("b2b_ct", data_out, CT_Z);

    run_op(KEY_C, PT_C, lowcyc);
    chk("appC_latency", 128'(lowcyc), 128'd10);
    chk("appC_ct", data_out, CT_C);
    @(negedge clk);

    // start while busy
    start = 1'b1; keyIn = KEY_B; data_in = PT_B;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; keyIn = rnd128(); data_in = rnd128();
    @(negedge clk);
    start = 1'b0;
    rises = 0;
    prev  = ready;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready && !prev) rises++;
      prev = ready;
    end
    chk("busy_start_rises", 128'(rises), 128'd1);
    chk("busy_start_ct", data_out, CT_B);

    // reset mid-operation
    start = 1'b1; keyIn = KEY_C; data_in = PT_C;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", {127'h0, ready}, 128'h1);
    chk("midrst_data_out", data_out, '0);
    repeat (12) @(negedge clk);
    chk("midrst_no_ct", data_out, '0);
    run_op(KEY_C, PT_C, lowcyc);
    chk("postrst_latency", 128'(lowcyc), 128'd10);
    chk("postrst_ct", data_out, CT_C);

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 2) == 0);
      keyIn   = rnd128();
      data_in = rnd128();
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_core.md
Name: aes128_encrypt_core

Overview:
Iterative AES-128 encryption engine (FIPS-197), encrypt only, one round per clock. It latches a 128-bit key and plaintext on a one-cycle start pulse and expands round keys on the fly. It presents the ciphertext with a ready level. It sits as a leaf crypto datapath under a bus or host controller that pulses start and watches for the rising edge of ready.

Parameters:
none (fixed AES-128: Nk=4, Nr=10).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; one clock; reset is synchronous and active-high.
start  input  1  one-cycle request; sampled only while idle (ready=1).
keyIn  input  128  cipher key; bits [127:120] are key byte 0.
data_in  input  128  plaintext block; bits [127:120] are state byte 0 (row 0, col 0); column-major, FIPS-197 order.
ready  output  1  1 = idle/result valid; 0 = encryption in progress.
data_out  output  128  ciphertext, same byte order as data_in; held stable while ready=1.

Behaviour:
- Reset (rst=1 at a clk edge): ready=1, data_out=0, round counter=0, internal state and round-key registers=0. Reset has priority over everything, including mid-operation (aborts; no result produced).
- Idle (ready=1):
  - If start=1 at edge E0: state <= data_in XOR keyIn (initial AddRoundKey); round_key <= keyIn; round <= 1; ready <= 0.
  - keyIn and data_in are sampled only at E0 and may change freely afterwards.
- Busy, rounds 1..9 (edges E1..E9):
  - round_key <= next key (KeyExpansion step with Rcon[round]).
  - state <= MixColumns(ShiftRows(SubBytes(state))) XOR next key.
  - round <= round+1.
- Final round (edge E10):
  - data_out <= ShiftRows(SubBytes(state)) XOR key10; no MixColumns.
  - ready <= 1; round <= 0.
- Latency: ciphertext valid and ready high after the 10th edge following the edge that sampled start. ready is low for exactly 10 cycles. Throughput: one block per 11 cycles minimum; start is accepted again on the edge right after ready rises.
- start while busy is ignored; the current operation completes undisturbed.
- start held high while idle: each accepted edge begins a new encryption.
- data_out keeps the previous ciphertext while busy. It changes only at the final-round edge or on reset.
- Key expansion: w' = w XOR (SubWord(RotWord(w3)) XOR {Rcon,0,0,0}) chained across words. Rcon = 01,02,04,08,10,20,40,80,1b,36.
- SubBytes uses the standard AES S-box, combinational (16 for state + 4 for key path). MixColumns uses GF(2^8) with polynomial 0x11b (xtime: shift left, XOR 0x1b if MSB was set).
- Fully synchronous, no latches, no multicycle paths.

Test Plan:
- Reset: hold rst=1 for 5 cycles -> ready=1, data_out=0; release, no start -> outputs unchanged.
- FIPS-197 App. B: keyIn=2B7E151628AED2A6ABF7158809CF4F3C, data_in=3243F6A8885A308D313198A2E0370734, start pulse -> ready 0 for 10 cycles, then ready=1, data_out=3925841d02dc09fbdc118597196a0b32.
- Back-to-back with input changes: after the previous result, keyIn=0, data_in=1, start pulse; change the inputs to random values 1 cycle later -> data_out=58e2fccefa7e3061367f1d57a4e7455a, unaffected by the later changes.
- FIPS-197 App. C.1: keyIn=000102030405060708090a0b0c0d0e0f, data_in=00112233445566778899aabbccddeeff -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Start while busy: pulse start again at cycle 4 of an operation with different inputs -> ignored; first ciphertext is correct and ready rises exactly once.
- Reset mid-operation: assert rst at cycle 5 of an encryption -> next edge ready=1, data_out=0, no ciphertext; a fresh start then produces a correct result.
